// File: rtl/sbd_pkg.sv
// Shared widths, FSM encoding and block-cipher helpers for the SBD round engine.
package sbd_pkg;

  localparam int unsigned BLOCK_W = 16;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NIBS    = BLOCK_W / NIB_W;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit i of the result comes from bit (4*i) mod 15; the MSB is fixed.
  function automatic logic [BLOCK_W-1:0] inv_perm(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < int'(BLOCK_W) - 1; i++) begin
      y[4'(i)] = x[4'((4 * i) % 15)];
    end
    y[BLOCK_W-1] = x[BLOCK_W-1];
    return y;
  endfunction

  // Key rotated left by r, then XORed with r.
  function automatic logic [BLOCK_W-1:0] round_key(input logic [BLOCK_W-1:0] k,
                                                   input logic [CNT_W-1:0]   r);
    logic [2*BLOCK_W-1:0] dbl;
    dbl = {k, k} << r;
    return dbl[2*BLOCK_W-1 -: BLOCK_W] ^ BLOCK_W'(r);
  endfunction

  function automatic logic [NIB_W-1:0] inv_sbox(input logic [NIB_W-1:0] v);
    logic [NIB_W-1:0] y;
    case (v)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      4'hF: y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/sbd_round.sv
// One combinational inverse round: inverse permutation, per-nibble inverse S-box, round-key XOR.
module sbd_round
  import sbd_pkg::*;
(
  input  logic [BLOCK_W-1:0] work,
  input  logic [BLOCK_W-1:0] rkey,
  output logic [BLOCK_W-1:0] result_c
);

  logic [BLOCK_W-1:0] permuted;

  assign permuted = inv_perm(work);

  for (genvar n = 0; n < NIBS; n++) begin : g_sbox
    assign result_c[n*NIB_W +: NIB_W] =
      inv_sbox(permuted[n*NIB_W +: NIB_W]) ^ rkey[n*NIB_W +: NIB_W];
  end

endmodule

// File: rtl/sbd_round_engine.sv
// Iterative SBD block decryptor, one inverse round per clock.
// Optional SBD_ROUND_TRACE_EN adds round_state/round_idx debug outputs.
module sbd_round_engine
  import sbd_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BLOCK_W-1:0] ciphertext,
  input  logic [BLOCK_W-1:0] key,
  output logic               busy,
  output logic               done,
  output logic [BLOCK_W-1:0] plaintext
`ifdef SBD_ROUND_TRACE_EN
  ,
  output logic [BLOCK_W-1:0] round_state,
  output logic [CNT_W-1:0]   round_idx
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NUM_ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ROUNDS);

  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [BLOCK_W-1:0] work, work_next;
  logic [BLOCK_W-1:0] key_q, key_next;
  logic [BLOCK_W-1:0] pt_next;
  logic [BLOCK_W-1:0] round_out;

  sbd_round u_round (
    .work     (work),
    .rkey     (round_key(key_q, cnt)),
    .result_c (round_out)
  );

  // Next-state and datapath; start is only honoured outside ROUND.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    work_next  = work;
    key_next   = key_q;
    pt_next    = plaintext;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = ROUND;
          work_next  = ciphertext ^ round_key(key, CNT_LAST);
          key_next   = key;
          cnt_next   = CNT_INIT;
        end else begin
          state_next = IDLE;
        end
      end
      ROUND: begin
        work_next = round_out;
        if (cnt == '0) begin
          state_next = DONE;
          pt_next    = round_out;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      key_q     <= '0;
      plaintext <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      work      <= work_next;
      key_q     <= key_next;
      plaintext <= pt_next;
      busy      <= (state_next == ROUND);
      done      <= (state_next == DONE);
    end
  end

`ifdef SBD_ROUND_TRACE_EN
  // Mirrors work/cnt only while busy, so the trace is quiet between operations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_state <= '0;
      round_idx   <= '0;
    end else begin
      round_state <= (state_next == ROUND) ? work_next : '0;
      round_idx   <= (state_next == ROUND) ? cnt_next : '0;
    end
  end
`endif

endmodule

// File: tb/tb_sbd_round_engine.sv
// Self-checking bench for sbd_round_engine: forward-cipher model plus plaintext scoreboard.
module tb_sbd_round_engine;
  import sbd_pkg::*;

  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ciphertext = '0;
  logic [15:0] key = '0;
  logic        busy;
  logic        done;
  logic [15:0] plaintext;
`ifdef SBD_ROUND_TRACE_EN
  logic [15:0] round_state;
  logic [3:0]  round_idx;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] key;
    logic [15:0] pt;
    logic [15:0] ct;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  sbd_round_engine #(.NUM_ROUNDS(NR)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ciphertext (ciphertext),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext)
`ifdef SBD_ROUND_TRACE_EN
    ,
    .round_state(round_state),
    .round_idx  (round_idx)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Forward cipher model (encryption direction).
  function automatic logic [3:0] sbox_f(input logic [3:0] v);
    case (v)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [15:0] perm_f(input logic [15:0] v);
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < 15; i++) o[(4 * i) % 15] = v[i];
    o[15] = v[15];
    return o;
  endfunction

  function automatic logic [15:0] rk_m(input logic [15:0] k, input int r);
    logic [15:0] a;
    a = (k << r) | (k >> (16 - r));
    return a ^ 16'(r);
  endfunction

  function automatic logic [15:0] encrypt(input logic [15:0] p, input logic [15:0] k);
    logic [15:0] w, s;
    w = p;
    for (int r = 0; r < NR; r++) begin
      s = w ^ rk_m(k, r);
      for (int n = 0; n < 4; n++) s[n*4 +: 4] = sbox_f(s[n*4 +: 4]);
      w = perm_f(s);
    end
    return w ^ rk_m(k, NR);
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding plaintext.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("plaintext", 32'(plaintext), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Start at the next edge and check the exact busy/done timeline.
  task automatic run_timed(input logic [15:0] c, input logic [15:0] k, input logic [15:0] p,
                           input int intrude_at, input logic [15:0] c2);
    start = 1'b1; ciphertext = c; key = k;
    exp_q.push_back(p);
    for (int j = 1; j <= NR; j++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
`ifdef SBD_ROUND_TRACE_EN
      chk("round_idx", 32'(round_idx), 32'(NR - j));
`endif
      start = (j == intrude_at);
      ciphertext = c2; key = ~k;
    end
    @(negedge clk);
    chk("done_at_n_plus_1", 32'(done), 32'd1);
    chk("busy_cleared", 32'(busy), 32'd0);
`ifdef SBD_ROUND_TRACE_EN
    chk("trace_idle", {round_state, 12'd0, round_idx}, 32'd0);
`endif
    start = 1'b0;
  endtask

  task automatic back_to_back(input logic [15:0] pa, input logic [15:0] ka,
                              input logic [15:0] pb, input logic [15:0] kb);
    int d1, d2;
    d1 = 0; d2 = 0;
    start = 1'b1; ciphertext = encrypt(pa, ka); key = ka;
    exp_q.push_back(pa);
    exp_q.push_back(pb);
    for (int t = 1; t <= 3 * NR + 4; t++) begin
      @(negedge clk);
      if (t == 1) begin ciphertext = encrypt(pb, kb); key = kb; end
      if (d1 != 0 && t == d1 + 1) begin
        chk("b2b_no_bubble", 32'(busy), 32'd1);
        start = 1'b0;
      end
      if (done === 1'b1) begin
        if (d1 == 0) d1 = t;
        else if (d2 == 0) d2 = t;
      end
    end
    chk("b2b_first_done", 32'(d1), 32'(NR + 1));
    chk("b2b_spacing", 32'(d2 - d1), 32'(NR + 1));
  endtask

  task automatic reset_mid_round(input logic [15:0] p, input logic [15:0] k);
    bit saw;
    saw = 1'b0;
    start = 1'b1; ciphertext = encrypt(p, k); key = k;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_plaintext", 32'(plaintext), 32'd0);
`ifdef SBD_ROUND_TRACE_EN
    chk("rst_trace", {round_state, 12'd0, round_idx}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3 * NR; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    chk("no_done_after_reset", 32'(saw), 32'd0);
  endtask

  initial begin
    vecs[0] = '{key: 16'h0000, pt: 16'h0000, ct: 16'h0};
    vecs[1] = '{key: 16'hFFFF, pt: 16'hFFFF, ct: 16'h0};
    vecs[2] = '{key: 16'hABCD, pt: 16'h1234, ct: 16'h0};
    vecs[3] = '{key: 16'h8000, pt: 16'h0001, ct: 16'h0};
    vecs[4] = '{key: 16'h5A5A, pt: 16'hA5A5, ct: 16'h0};
    vecs[5] = '{key: 16'h0F0F, pt: 16'hCAFE, ct: 16'h0};
    foreach (vecs[i]) vecs[i].ct = encrypt(vecs[i].pt, vecs[i].key);

    #2 reset = 1'b1;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_plaintext", 32'(plaintext), 32'd0);

    chk("inv_perm_0002", 32'(inv_perm(16'h0002)), 32'h0010);
    chk("inv_perm_8000", 32'(inv_perm(16'h8000)), 32'h8000);
    chk("round_key_1234_1", 32'(round_key(16'h1234, 4'd1)), 32'h2469);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_timed(vecs[i].ct, vecs[i].key, vecs[i].pt, 0, 16'h0);

    // A start during ROUND carries a different block and must be ignored.
    run_timed(encrypt(16'h7E57, 16'h1357), 16'h1357, 16'h7E57, 2, 16'hDEAD);

    back_to_back(16'h3C3C, 16'h2468, 16'hBEEF, 16'h9753);

    reset_mid_round(16'h4242, 16'h1111);

    for (int i = 0; i < 256; i++) begin
      logic [15:0] p, k;
      p = 16'($urandom);
      k = 16'($urandom);
      start = 1'b1; ciphertext = encrypt(p, k); key = k;
      exp_q.push_back(p);
      @(negedge clk);
      start = 1'b0;
      ciphertext = 16'($urandom);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sbd_round_engine.md
SBD_ROUND_ENGINE -- requirements
Module: sbd_round_engine

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 4 (legal 1..15): number of inverse rounds applied after the initial key mix.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request to decrypt the current ciphertext/key.
REQ-005 SHALL have port ciphertext, input, 16: block to decrypt, sampled on an accepted start.
REQ-006 SHALL have port key, input, 16: master key, sampled on an accepted start.
REQ-007 SHALL have port busy, output, 1: high while rounds are in progress.
REQ-008 SHALL have port done, output, 1: one-cycle pulse marking plaintext valid.
REQ-009 SHALL have port plaintext, output, 16: result register, held until the next accepted start.

Function
REQ-010 SHALL implement FSM states IDLE, ROUND, DONE; busy = (state == ROUND); done = (state == DONE).
REQ-011 SHALL accept start only in IDLE or DONE; start in ROUND SHALL be ignored with no effect on state, counter or captured operands.
REQ-012 On an accepted start, SHALL load work = ciphertext ^ rk(NUM_ROUNDS), capture key, set round counter to NUM_ROUNDS-1 and enter ROUND.
REQ-013 Each ROUND cycle SHALL compute work <= invS(invP(work)) ^ rk(cnt); at cnt == 0 it SHALL write plaintext with that value and enter DONE, else decrement cnt.
REQ-014 invP SHALL be out[i] = in[(4*i) mod 15] for i = 0..14, out[15] = in[15].
REQ-015 invS SHALL apply the team's existing 4-bit inverse S-box independently to each of the 4 nibbles.
REQ-016 rk(r) SHALL be the captured key rotated left by r bits, XOR with zero-extended 4-bit r.
REQ-017 Latency: start accepted at edge k -> busy high cycles k+1..k+NUM_ROUNDS, done high exactly at cycle k+NUM_ROUNDS+1.
REQ-018 DONE SHALL return to IDLE after one cycle unless start is high, in which case it SHALL re-enter ROUND (back-to-back, no idle bubble).
REQ-019 The round counter SHALL never wrap; width SHALL be 4 bits.

Reset
REQ-020 reset SHALL immediately force state IDLE, busy 0, done 0, plaintext 0x0000, counter 0, work 0x0000.
REQ-021 reset asserted mid-decryption SHALL abort the operation; no done pulse SHALL follow its deassertion.

Configuration
REQ-022 Macro SBD_ROUND_TRACE_EN: when defined, SHALL add output round_state (16) = work and output round_idx (4) = cnt, both valid while busy, 0 otherwise; when undefined these ports SHALL not exist and behaviour is otherwise identical.

Structure
REQ-023 Package sbd_pkg SHALL hold BLOCK_W = 16, NIB_W = 4, the FSM state enum, and functions inv_perm and round_key.
REQ-024 Sub-module sbd_round (combinational: invP, 4 inverse S-box instances, key XOR) SHALL be instantiated once.

Verification
REQ-025 Reset mid-round (NUM_ROUNDS = 4, reset asserted on the 2nd busy cycle) -> all outputs 0 immediately; no done pulse afterwards.
REQ-026 start at edge k, NUM_ROUNDS = 4 -> busy cycles k+1..k+4, done only at k+5; plaintext matches the bench model's decryption of the sampled ciphertext/key.
REQ-027 start pulsed in ROUND with different ciphertext -> ignored; result equals the decryption of the first ciphertext.
REQ-028 start held high through DONE -> second operation begins the cycle after done; two done pulses exactly NUM_ROUNDS+1 cycles apart.
REQ-029 Unit checks: inv_perm(0x0002) = 0x0010, inv_perm(0x8000) = 0x8000, round_key(0x1234, 1) = 0x2469.
REQ-030 Round trip: 256 random key/plaintext pairs encrypted by the bench model, then decrypted -> 0 mismatches; with SBD_ROUND_TRACE_EN defined, round_idx sequence is 3, 2, 1, 0.
